// File: rtl/run_ctrl_pkg.sv
// Shared types for the run controller: state encoding and its width.
package run_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_IDLE = 3'd3,
    ST_END       = 3'd4
  } state_t;

endpackage

// File: rtl/run_controller_if.sv
// Control/status bundle between the run controller (master) and the bench/DUT side (slave).
interface run_controller_if #(
  parameter int NUM_CH    = 2,
  parameter int NUM_RUNS  = 1,
  parameter int CNT_WIDTH = 32
);
  import run_ctrl_pkg::*;

  localparam int RUN_IDX_W = $clog2(NUM_RUNS + 1);

  logic                 start;
  logic [NUM_CH-1:0]    ch_mask;
  logic [NUM_CH-1:0]    busy;
  logic                 dut_reset;
  logic                 running;
  logic                 done;
  logic                 pass;
  logic                 timeout;
  logic                 finish;
  logic [RUN_IDX_W-1:0] run_idx;
  logic [CNT_WIDTH-1:0] last_run_cycles;
  logic [STATE_W-1:0]   state;

  modport master (
    input  start, ch_mask, busy,
    output dut_reset, running, done, pass, timeout, finish,
           run_idx, last_run_cycles, state
  );

  modport slave (
    output start, ch_mask, busy,
    input  dut_reset, running, done, pass, timeout, finish,
           run_idx, last_run_cycles, state
  );

endinterface

// File: rtl/run_ctrl_watchdog.sv
// Per-run watchdog: counts enabled cycles since the last clear and flags the limit cycle.
module run_ctrl_watchdog #(
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  // NOTE: count_d gets a value on every path before any condition, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Fires in the TIMEOUT_CYCLES-th enabled cycle so the controller leaves on that edge.
  assign expired = enable && (count_q >= LIMIT - 1'b1);

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/run_controller.sv
// Run sequencer: reset -> wait busy -> wait idle, repeated NUM_RUNS times.
// Optional watchdog built when RUN_CTRL_WATCHDOG_EN is defined.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int RESET_CYCLES   = 4,
  parameter int NUM_RUNS       = 1,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic             clock,
  input logic             resetn,
  run_controller_if.master bus
);

  localparam int RUN_IDX_W = $clog2(NUM_RUNS + 1);
  localparam int RST_W     = $clog2(RESET_CYCLES + 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);

  state_t               state_q, state_d;
  logic [NUM_CH-1:0]    mask_q, mask_d;
  logic [NUM_CH-1:0]    seen_q, seen_d;
  logic [RST_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic [CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
  logic [RUN_IDX_W-1:0] run_idx_q, run_idx_d;
  logic [CNT_WIDTH-1:0] last_q, last_d;
  logic                 pass_q, pass_d;
  logic                 timeout_q, timeout_d;
  logic                 finish_q, finish_d;
  logic                 dut_reset_q, dut_reset_d;
  logic                 running_q, running_d;
  logic                 done_q, done_d;

  logic                 wd_clear, wd_enable, wd_expired;
  logic [NUM_CH-1:0]    busy_m;
  logic [CNT_WIDTH-1:0] cnt_inc;

  assign busy_m  = bus.busy & mask_q;
  assign cnt_inc = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    seen_d    = seen_q;
    rst_cnt_d = rst_cnt_q;
    run_cnt_d = run_cnt_q;
    run_idx_d = run_idx_q;
    last_d    = last_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    finish_d  = 1'b0;
    wd_clear  = 1'b0;
    wd_enable = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_END: begin
        if (bus.start) begin
          mask_d    = bus.ch_mask;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          if (bus.ch_mask == '0) begin
            state_d  = ST_END;
            finish_d = 1'b1;
          end else begin
            run_idx_d = '0;
            rst_cnt_d = '0;
            state_d   = ST_RESET;
          end
        end
      end
      ST_RESET: begin
        seen_d    = '0;
        run_cnt_d = '0;
        wd_clear  = 1'b1;
        if (rst_cnt_q == RST_LAST) state_d = ST_WAIT_BUSY;
        else                       rst_cnt_d = rst_cnt_q + 1'b1;
      end
      ST_WAIT_BUSY: begin
        run_cnt_d = cnt_inc;
        wd_enable = 1'b1;
        seen_d    = seen_q | busy_m;
        if (wd_expired) begin
          last_d    = cnt_inc;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          finish_d  = 1'b1;
          state_d   = ST_END;
        end else if ((seen_q | busy_m) == mask_q) begin
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        run_cnt_d = cnt_inc;
        wd_enable = 1'b1;
        // Completion is checked first so it wins over a same-cycle watchdog expiry.
        if (busy_m == '0) begin
          last_d = cnt_inc;
          if (int'(run_idx_q) + 1 < NUM_RUNS) begin
            run_idx_d = run_idx_q + 1'b1;
            rst_cnt_d = '0;
            state_d   = ST_RESET;
          end else begin
            pass_d   = 1'b1;
            finish_d = 1'b1;
            state_d  = ST_END;
          end
        end else if (wd_expired) begin
          last_d    = cnt_inc;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          finish_d  = 1'b1;
          state_d   = ST_END;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    dut_reset_d = (state_d != ST_WAIT_BUSY) && (state_d != ST_WAIT_IDLE);
    running_d   = (state_d == ST_RESET) || (state_d == ST_WAIT_BUSY) ||
                  (state_d == ST_WAIT_IDLE);
    done_d      = (state_d == ST_END);
  end

`ifdef RUN_CTRL_WATCHDOG_EN
  run_ctrl_watchdog #(
    .CNT_WIDTH      (CNT_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock   (clock),
    .resetn  (resetn),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );
`else
  logic unused_wd;
  assign wd_expired = 1'b0;
  assign unused_wd  = ^{wd_clear, wd_enable, TIMEOUT_CYCLES};
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      seen_q      <= '0;
      rst_cnt_q   <= '0;
      run_cnt_q   <= '0;
      run_idx_q   <= '0;
      last_q      <= '0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      finish_q    <= 1'b0;
      dut_reset_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      seen_q      <= seen_d;
      rst_cnt_q   <= rst_cnt_d;
      run_cnt_q   <= run_cnt_d;
      run_idx_q   <= run_idx_d;
      last_q      <= last_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      finish_q    <= finish_d;
      dut_reset_q <= dut_reset_d;
      running_q   <= running_d;
      done_q      <= done_d;
    end
  end

  assign bus.state           = state_q;
  assign bus.dut_reset       = dut_reset_q;
  assign bus.running         = running_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.timeout         = timeout_q;
  assign bus.finish          = finish_q;
  assign bus.run_idx         = run_idx_q;
  assign bus.last_run_cycles = last_q;

endmodule
